ins_fetch: RTL and testbench

INS_FETCH -- requirements
Module: ins_fetch

---
 rtl/cpu_pkg.sv | 11 +
 rtl/ins_fetch.sv | 86 ++++++++
 tb/tb_ins_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants and fetch-state encoding for the CPU front end.
package cpu_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_JMP  = 8'h08;
   localparam logic [7:0] OP_BAN  = 8'h09;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [1:0] {FETCH, WAIT, ISSUE, HALT} fetch_state_e;

endpackage

// File: rtl/ins_fetch.sv
// ins_fetch: FETCH/WAIT/ISSUE/HALT instruction fetcher with PC, jump and branch-if-negative.
// Optional macro INS_FETCH_ICOUNT_EN adds an issued-instruction counter on port icount.
module ins_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_data,
   input  logic              mem_valid,
   output logic [15:0]       outins,
   output logic              ins_valid,
   input  logic              pcJMP,
   input  logic              ban,
   input  logic              stop,
   output logic [ADDR_W-1:0] pc,
`ifdef INS_FETCH_ICOUNT_EN
   output logic [15:0]       icount,
`endif
   output logic              halted
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       outins_q, outins_d;
   logic [7:0]        op;

   assign op = outins_q[15:8];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      outins_d = outins_q;
      case (state_q)
         FETCH: state_d = WAIT;
         WAIT: begin
            outins_d = mem_valid ? mem_data : outins_q;
            state_d  = mem_valid ? ISSUE : WAIT;
         end
         ISSUE: begin
            state_d = (stop || op == OP_HALT) ? HALT : FETCH;
            if (!(stop || op == OP_HALT))
               pc_d = (pcJMP || (ban && op == OP_BAN)) ? outins_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
         end
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         outins_q <= 16'h0000;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         outins_q <= outins_d;
      end
   end

   // Strobes are masked while rst is held so nothing leaks out before release.
   assign mem_rd    = !rst && state_q == FETCH;
   assign ins_valid = !rst && state_q == ISSUE;
   assign halted    = !rst && state_q == HALT;
   assign mem_addr  = pc_q;
   assign pc        = pc_q;
   assign outins    = outins_q;

`ifdef INS_FETCH_ICOUNT_EN
   logic [15:0] icount_q;

   always_ff @(posedge clk) begin
      if (rst)
         icount_q <= 16'h0000;
      else if (state_q == ISSUE)
         icount_q <= icount_q + 16'd1;
   end

   assign icount = icount_q;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: table-driven fetch/issue vectors with an address/word scoreboard plus reset and halt sequences.
module tb_ins_fetch;

   logic        clk = 0;
   logic        rst = 1;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data = 16'h0000;
   logic        mem_valid = 0;
   logic [15:0] outins;
   logic        ins_valid;
   logic        pcJMP = 0;
   logic        ban = 0;
   logic        stop = 0;
   logic [7:0]  pc;
   logic        halted;
`ifdef INS_FETCH_ICOUNT_EN
   logic [15:0] icount;
`endif

   ins_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_valid(mem_valid), .outins(outins), .ins_valid(ins_valid), .pcJMP(pcJMP),
      .ban(ban), .stop(stop), .pc(pc),
`ifdef INS_FETCH_ICOUNT_EN
      .icount(icount),
`endif
      .halted(halted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        rst_b;
      logic [7:0]  addr;
      logic [15:0] word;
      logic        jmp, ban, stop, junk;
      int          dly;
      logic [7:0]  exp_pc;
      logic        exp_halt;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] word;
   } sb_t;

   vec_t v[13];
   sb_t  sb[$];
   sb_t  e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_iss = 0;
   int   last = 0;
   int   bad;
   int   n;
   bit   first = 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1; mem_valid = 0; pcJMP = 0; ban = 0; stop = 0;
      repeat (3) @(negedge clk);
      chk("rst_pc", pc, 8'h00);
      chk("rst_outins", outins, 16'h0000);
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_ins_valid", ins_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
`ifdef INS_FETCH_ICOUNT_EN
      chk("rst_icount", icount, 16'h0000);
`endif
      rst = 0;
      #1;
      chk("first_rd", mem_rd, 1'b1);
      n_iss = 0; first = 1; sb.delete();
   endtask

   initial begin
      //       rst addr   word      jmp ban stp junk dly exp_pc halt
      v[0]  = '{1, 8'h00, 16'h0100, 0, 0, 0, 0, 0, 8'h01, 0};
      v[1]  = '{0, 8'h01, 16'h0200, 0, 0, 0, 0, 0, 8'h02, 0};
      v[2]  = '{0, 8'h02, 16'h0005, 0, 0, 0, 1, 2, 8'h03, 0};
      v[3]  = '{0, 8'h03, 16'h0812, 1, 0, 0, 0, 0, 8'h12, 0};
      v[4]  = '{0, 8'h12, 16'h0920, 0, 1, 0, 0, 0, 8'h20, 0};
      v[5]  = '{0, 8'h20, 16'h0920, 0, 0, 0, 0, 1, 8'h21, 0};
      v[6]  = '{0, 8'h21, 16'h0120, 0, 1, 0, 0, 0, 8'h22, 0};
      v[7]  = '{0, 8'h22, 16'h08FF, 1, 0, 0, 0, 0, 8'hFF, 0};
      v[8]  = '{0, 8'hFF, 16'h0130, 0, 0, 0, 0, 0, 8'h00, 0};
      v[9]  = '{0, 8'h00, 16'h0305, 0, 0, 0, 0, 0, 8'h01, 0};
      v[10] = '{0, 8'h01, 16'h0400, 0, 0, 1, 0, 0, 8'h01, 1};
      v[11] = '{1, 8'h00, 16'h0100, 0, 0, 0, 0, 0, 8'h01, 0};
      v[12] = '{0, 8'h01, 16'hFF00, 0, 0, 0, 0, 0, 8'h01, 1};

      for (int i = 0; i < 13; i++) begin
         if (v[i].rst_b) do_reset();
         n = 0;
         while (!mem_rd && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("mem_rd", mem_rd, 1'b1);
         chk("mem_addr", mem_addr, v[i].addr);
         sb.push_back('{v[i].addr, v[i].word});
         // Responses and decoder requests outside WAIT/ISSUE must be ignored.
         if (v[i].junk) begin
            mem_valid = 1; mem_data = 16'hDEAD; pcJMP = 1; stop = 1;
         end
         @(negedge clk);
         mem_valid = 0; pcJMP = 0; stop = 0;
         chk("wait_rd", mem_rd, 1'b0);
         repeat (v[i].dly) @(negedge clk);
         mem_valid = 1; mem_data = v[i].word;
         @(negedge clk);
         mem_valid = 0; mem_data = 16'hBEEF;
         chk("ins_valid", ins_valid, 1'b1);
         if (ins_valid) begin
            if (sb.size() == 0) chk("sb_empty", 1'b1, 1'b0);
            else begin
               e = sb.pop_front();
               chk("outins", outins, e.word);
               chk("issue_pc", pc, e.addr);
            end
         end
         if (!first) chk("period", cyc - last, 3 + v[i].dly);
         first = 0; last = cyc;
         pcJMP = v[i].jmp; ban = v[i].ban; stop = v[i].stop;
         @(negedge clk);
         pcJMP = 0; ban = 0; stop = 0;
         n_iss++;
         chk("next_pc", pc, v[i].exp_pc);
         chk("halted", halted, v[i].exp_halt);
`ifdef INS_FETCH_ICOUNT_EN
         if (v[i].exp_halt) chk("icount", icount, n_iss);
`endif
      end

      bad = 0;
      for (int k = 0; k < 20; k++) begin
         mem_valid = 1; mem_data = 16'h1111; pcJMP = 1;
         @(negedge clk);
         if (mem_rd || ins_valid || !halted) bad++;
      end
      mem_valid = 0; pcJMP = 0;
      chk("halt_quiet", bad, 0);
      chk("halt_outins", outins, 16'hFF00);
      chk("halt_pc", pc, 8'h01);
`ifdef INS_FETCH_ICOUNT_EN
      chk("halt_icount", icount, n_iss);
`endif

      do_reset();
      chk("wr_addr", mem_addr, 8'h00);
      @(negedge clk);
      rst = 1; mem_valid = 1; mem_data = 16'h1234;
      @(negedge clk);
      chk("wr_outins", outins, 16'h0000);
      chk("wr_pc", pc, 8'h00);
      chk("wr_mem_rd", mem_rd, 1'b0);
      rst = 0; mem_valid = 0;
      #1;
      chk("wr_refetch", mem_rd, 1'b1);
      chk("wr_refetch_addr", mem_addr, 8'h00);
      @(negedge clk);
      mem_valid = 1; mem_data = 16'h0207;
      @(negedge clk);
      mem_valid = 0;
      chk("wr_issue", ins_valid, 1'b1);
      chk("wr_issue_outins", outins, 16'h0207);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
